// File: rtl/eth_pkt_fifo.sv
// Store-and-forward Ethernet packet FIFO between a non-stallable MAC RX stream
// and a MAC TX stream. Frames are only released to m_axis once their tlast beat
// is committed. Bad frames (tuser on tlast) and frames that overflow are discarded.
// Optional macro ETH_PKT_FIFO_STATS_EN enables the three statistics counters;
// without it the counter ports read constant zero.
module eth_pkt_fifo #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned DEPTH      = 512
) (
  input  logic                    clk156,
  input  logic                    eth_rst_n,
  input  logic                    s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic [31:0]             stat_rx_frames,
  output logic [31:0]             stat_drop_bad,
  output logic [31:0]             stat_drop_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   wr_ptr, wr_ptr_nxt;
  logic [PW-1:0]   commit_ptr, commit_ptr_nxt;
  logic [PW-1:0]   rd_ptr, rd_ptr_nxt;
  logic            full_c;
  logic            wr_en_c;
  logic            load_c;
  logic            out_valid_nxt;
  logic [EW-1:0]   mem [DEPTH];

  // Occupancy counts uncommitted beats and uses the registered read pointer
  assign full_c = (wr_ptr - rd_ptr) == DEPTH_P;

  // Input FSM next state: accept, commit, or roll back the frame in progress
  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    wr_en_c        = 1'b0;
    if (s_axis_tvalid) begin
      if (state == ST_DROP) begin
        if (s_axis_tlast) begin
          state_nxt = ST_IDLE;
        end
      end else if (full_c) begin
        wr_ptr_nxt = commit_ptr;
        state_nxt  = s_axis_tlast ? ST_IDLE : ST_DROP;
      end else if (s_axis_tlast && s_axis_tuser) begin
        wr_ptr_nxt = commit_ptr;
        state_nxt  = ST_IDLE;
      end else begin
        wr_en_c    = 1'b1;
        wr_ptr_nxt = wr_ptr + PW'(1);
        if (s_axis_tlast) begin
          commit_ptr_nxt = wr_ptr + PW'(1);
          state_nxt      = ST_IDLE;
        end else begin
          state_nxt = ST_RECV;
        end
      end
    end
  end

  // Output register refills from committed storage whenever it empties or drains
  always_comb begin
    load_c        = (rd_ptr != commit_ptr) && (!m_axis_tvalid || m_axis_tready);
    rd_ptr_nxt    = load_c ? rd_ptr + PW'(1) : rd_ptr;
    out_valid_nxt = load_c || (m_axis_tvalid && !m_axis_tready);
  end

  // Input state and write/commit pointers
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
    end
  end

  // Beat storage, contents left unreset
  always_ff @(posedge clk156) begin
    if (wr_en_c) begin
      mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end
  end

  // Read pointer and one-entry output register
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      rd_ptr        <= rd_ptr_nxt;
      m_axis_tvalid <= out_valid_nxt;
      if (load_c) begin
        {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // Fill level: beats written (incl. partial frame) minus beats handed to the MAC
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      fill_level <= '0;
    end else begin
      fill_level <= wr_ptr_nxt - rd_ptr_nxt + PW'(out_valid_nxt);
    end
  end

  assign m_axis_tuser = 1'b0;

`ifdef ETH_PKT_FIFO_STATS_EN
  logic frame_end_c;
  logic accept_c;
  logic inc_rx_c;
  logic inc_bad_c;
  logic inc_ovf_c;

  // Classify each frame end; overflow wins over a bad-frame flag
  always_comb begin
    frame_end_c = s_axis_tvalid && s_axis_tlast;
    accept_c    = (state != ST_DROP) && !full_c;
    inc_ovf_c   = frame_end_c && !accept_c;
    inc_bad_c   = frame_end_c && accept_c && s_axis_tuser;
    inc_rx_c    = frame_end_c && accept_c && !s_axis_tuser;
  end

  // Saturating statistics counters
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      stat_rx_frames <= '0;
      stat_drop_bad  <= '0;
      stat_drop_ovf  <= '0;
    end else begin
      if (inc_rx_c && (stat_rx_frames != 32'hFFFF_FFFF)) begin
        stat_rx_frames <= stat_rx_frames + 32'd1;
      end
      if (inc_bad_c && (stat_drop_bad != 32'hFFFF_FFFF)) begin
        stat_drop_bad <= stat_drop_bad + 32'd1;
      end
      if (inc_ovf_c && (stat_drop_ovf != 32'hFFFF_FFFF)) begin
        stat_drop_ovf <= stat_drop_ovf + 32'd1;
      end
    end
  end
`else
  assign stat_rx_frames = 32'd0;
  assign stat_drop_bad  = 32'd0;
  assign stat_drop_ovf  = 32'd0;
`endif

endmodule

// File: tb/tb_eth_pkt_fifo.sv
// Bench for eth_pkt_fifo (DEPTH=16): frame-level model with committed-beat queue,
// checked every cycle, plus hand-computed expectations for the directed scenarios.
module tb_eth_pkt_fifo;

  localparam int unsigned DEPTH = 16;

  logic        clk156 = 1'b0;
  logic        eth_rst_n;
  logic        s_axis_tvalid;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [4:0]  fill_level;
  logic [31:0] stat_rx_frames;
  logic [31:0] stat_drop_bad;
  logic [31:0] stat_drop_ovf;

  eth_pkt_fifo #(.DATA_WIDTH(64), .KEEP_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk156(clk156), .eth_rst_n(eth_rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .fill_level(fill_level), .stat_rx_frames(stat_rx_frames),
    .stat_drop_bad(stat_drop_bad), .stat_drop_ovf(stat_drop_ovf)
  );

  always #5 clk156 = ~clk156;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] st(input int unsigned v);
`ifdef ETH_PKT_FIFO_STATS_EN
    return v;
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  // Model: W = beats written incl. partial frame, C = committed, K = consumed by MAC,
  // V = output holds a beat (a committed beat becomes visible one cycle after commit).
  int unsigned m_w = 0, m_c = 0, m_k = 0;
  int unsigned m_rx = 0, m_bad = 0, m_ovf = 0;
  bit          m_v = 1'b0;
  bit          m_drop = 1'b0;
  beat_t       exp_q[$];
  beat_t       part_q[$];
  int          dut_hs = 0;

  // Per-cycle compare, then advance the model by the events of the coming edge
  always @(negedge clk156) begin
    beat_t b;
    bit    hs;
    bit    v_new;
    bit    full;
    if (!eth_rst_n) begin
      check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_tlast", 64'(m_axis_tlast), 64'd0);
      check("rst_tdata", m_axis_tdata, 64'd0);
      check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
      check("rst_fill", 64'(fill_level), 64'd0);
      check("rst_stats", {stat_rx_frames, stat_drop_bad ^ stat_drop_ovf}, 64'd0);
      m_w = 0; m_c = 0; m_k = 0; m_v = 1'b0; m_drop = 1'b0;
      m_rx = 0; m_bad = 0; m_ovf = 0;
      exp_q.delete();
      part_q.delete();
    end else begin
      check("tvalid", 64'(m_axis_tvalid), 64'(m_v));
      if (m_v && m_axis_tvalid && exp_q.size() > 0) begin
        check("tdata", m_axis_tdata, exp_q[0].d);
        check("tkeep_tlast", 64'({m_axis_tkeep, m_axis_tlast}), 64'({exp_q[0].k, exp_q[0].l}));
      end
      check("tuser", 64'(m_axis_tuser), 64'd0);
      check("fill_level", 64'(fill_level), 64'(5'(m_w - m_k)));
      check("stat_rx", 64'(stat_rx_frames), 64'(st(m_rx)));
      check("stat_bad", 64'(stat_drop_bad), 64'(st(m_bad)));
      check("stat_ovf", 64'(stat_drop_ovf), 64'(st(m_ovf)));
      if (m_axis_tvalid && m_axis_tready) dut_hs++;

      hs    = m_v && m_axis_tready;
      v_new = m_c > (m_k + (hs ? 1 : 0));
      full  = (m_w - m_k - (m_v ? 1 : 0)) == DEPTH;
      if (hs) begin
        m_k++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (s_axis_tvalid) begin
        b = '{d: s_axis_tdata, k: s_axis_tkeep, l: s_axis_tlast};
        if (m_drop) begin
          if (s_axis_tlast) begin m_drop = 1'b0; m_ovf++; end
        end else if (full) begin
          m_w = m_c;
          part_q.delete();
          if (s_axis_tlast) m_ovf++;
          else m_drop = 1'b1;
        end else if (s_axis_tlast && s_axis_tuser) begin
          m_w = m_c;
          part_q.delete();
          m_bad++;
        end else begin
          part_q.push_back(b);
          m_w++;
          if (s_axis_tlast) begin
            foreach (part_q[i]) exp_q.push_back(part_q[i]);
            part_q.delete();
            m_c = m_w;
            m_rx++;
          end
        end
      end
      m_v = v_new;
    end
  end

  bit rand_rdy = 1'b0;

  // Random backpressure while enabled
  always @(posedge clk156) begin
    if (rand_rdy) begin
      #1;
      m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  logic [63:0] fr_d [0:31];

  task automatic idle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit bad);
    logic [63:0] d;
    for (int i = 0; i < len; i++) begin
      d = {$urandom, $urandom};
      if (i < 32) fr_d[i] = d;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tkeep  = (i == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
      s_axis_tlast  = (i == len - 1);
      s_axis_tuser  = (i == len - 1) ? bad : 1'($urandom_range(0, 1));
      @(posedge clk156); #1;
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk156); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_w != m_k) && (n < 3000)) begin
      @(posedge clk156); #1;
      n++;
    end
    check("drain_bound", 64'(n < 3000), 64'd1);
  endtask

  int hs_base;
  int ngood = 0;
  int nbad = 0;

  initial begin
    eth_rst_n = 1'b0;
    m_axis_tready = 1'b0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    idle();
    cycles(3);
    eth_rst_n = 1'b1;
    check("post_rst_fill", 64'(fill_level), 64'd0);
    check("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);

    // 8-beat good frame, first beat two cycles after tlast
    m_axis_tready = 1'b1;
    hs_base = dut_hs;
    send_frame(8, 1'b0);
    idle();
    check("lat_n1_tvalid", 64'(m_axis_tvalid), 64'd0);
    cycles(1);
    check("lat_n2_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("lat_n2_tdata", m_axis_tdata, fr_d[0]);
    drain();
    check("f8_beats_out", 64'(dut_hs - hs_base), 64'd8);
    check("f8_stat_rx", 64'(stat_rx_frames), 64'(st(1)));

    // Bad 6-beat frame followed by good 4-beat frame
    hs_base = dut_hs;
    send_frame(6, 1'b1);
    send_frame(4, 1'b0);
    idle();
    drain();
    cycles(2);
    check("bad_beats_out", 64'(dut_hs - hs_base), 64'd4);
    check("bad_stat_bad", 64'(stat_drop_bad), 64'(st(1)));
    check("bad_stat_rx", 64'(stat_rx_frames), 64'(st(2)));
    check("bad_fill", 64'(fill_level), 64'd0);

    // Two 10-beat frames with no drain: second overflows
    m_axis_tready = 1'b0;
    send_frame(10, 1'b0);
    send_frame(10, 1'b0);
    idle();
    cycles(2);
    check("ovf_fill", 64'(fill_level), 64'd10);
    check("ovf_stat_ovf", 64'(stat_drop_ovf), 64'(st(1)));
    check("ovf_stat_rx", 64'(stat_rx_frames), 64'(st(3)));
    check("ovf_tvalid", 64'(m_axis_tvalid), 64'd1);
    hs_base = dut_hs;
    m_axis_tready = 1'b1;
    drain();
    check("ovf_beats_out", 64'(dut_hs - hs_base), 64'd10);

    // Exactly DEPTH beats fits, DEPTH+1 is dropped
    m_axis_tready = 1'b0;
    send_frame(16, 1'b0);
    idle();
    cycles(2);
    check("full16_fill", 64'(fill_level), 64'd16);
    check("full16_tvalid", 64'(m_axis_tvalid), 64'd1);
    hs_base = dut_hs;
    m_axis_tready = 1'b1;
    drain();
    check("full16_beats_out", 64'(dut_hs - hs_base), 64'd16);
    check("full16_stat_rx", 64'(stat_rx_frames), 64'(st(4)));
    m_axis_tready = 1'b0;
    send_frame(17, 1'b0);
    idle();
    cycles(3);
    check("f17_fill", 64'(fill_level), 64'd0);
    check("f17_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("f17_stat_ovf", 64'(stat_drop_ovf), 64'(st(2)));
    check("f17_stat_rx", 64'(stat_rx_frames), 64'(st(4)));

    // 200 frames with random backpressure, paced so none overflow
    rand_rdy = 1'b1;
    for (int f = 0; f < 200; f++) begin
      int len;
      bit bad;
      int n;
      len = $urandom_range(1, 12);
      bad = ($urandom_range(0, 7) == 0);
      idle();
      n = 0;
      while (((m_w - m_k) + len > DEPTH) && (n < 1000)) begin
        @(posedge clk156); #1;
        n++;
      end
      if (n >= 1000) check("space_bound", 64'(n), 64'd0);
      send_frame(len, bad);
      if (bad) nbad++;
      else ngood++;
    end
    idle();
    rand_rdy = 1'b0;
    cycles(1);
    m_axis_tready = 1'b1;
    drain();
    cycles(2);
    check("rand_stat_rx", 64'(stat_rx_frames), 64'(st(4 + ngood)));
    check("rand_stat_bad", 64'(stat_drop_bad), 64'(st(1 + nbad)));
    check("rand_stat_ovf", 64'(stat_drop_ovf), 64'(st(2)));
    check("rand_fill", 64'(fill_level), 64'd0);

    // Reset while beat 3 of 8 is on the output
    begin
      int n;
      hs_base = dut_hs;
      send_frame(8, 1'b0);
      idle();
      n = 0;
      while ((dut_hs - hs_base < 2) && (n < 100)) begin
        @(posedge clk156); #1;
        n++;
      end
      check("rst_wait_bound", 64'(n < 100), 64'd1);
      check("pre_rst_tdata", m_axis_tdata, fr_d[2]);
      eth_rst_n = 1'b0;
      #1;
      check("async_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("async_rst_fill", 64'(fill_level), 64'd0);
      @(posedge clk156); #1;
      eth_rst_n = 1'b1;
      hs_base = dut_hs;
      send_frame(5, 1'b0);
      idle();
      drain();
      check("post_rst_beats_out", 64'(dut_hs - hs_base), 64'd5);
      check("post_rst_stat_rx", 64'(stat_rx_frames), 64'(st(1)));
    end

    cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
